// File: rtl/ram_banked_if.sv
// Request/response bundle for the banked single-port RAM.
interface ram_banked_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
);
  logic             req;
  logic             rw;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data_in;
  logic             wipe;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;

  modport master (
    output req, rw, addr, data_in, wipe,
    input  ready, busy, data_out, rd_valid
  );

  modport slave (
    input  req, rw, addr, data_in, wipe,
    output ready, busy, data_out, rd_valid
  );
endinterface

// File: rtl/ram_banked.sv
// Parametrised single-port RAM split into sub-banks, with registered read
// and a row-sequenced bulk-clear engine.
module ram_banked #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned BANKS         = 2,
  parameter int unsigned INTERLEAVE    = 0,
  parameter int unsigned WIPE_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         clr,
  ram_banked_if.slave  bus
);

  localparam int unsigned ROWS = DEPTH / BANKS;
  localparam int unsigned BW   = $clog2(BANKS);
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned BSW  = (BW > 0) ? BW : 1;
  localparam int unsigned RSW  = (RW > 0) ? RW : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WIPE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [RSW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rv_q, rv_d;
  logic             mem_we_c;
  logic             wipe_we_c;
  logic [31:0]      addr_w;
  logic [BSW-1:0]   bank_c;
  logic [RSW-1:0]   row_c;
  logic [WIDTH-1:0] mem_q [BANKS][ROWS];

  assign addr_w = 32'(bus.addr);

  // Bank/row split; shifts and masks stay valid when BANKS or ROWS is 1.
  always_comb begin
    if (INTERLEAVE == 0) begin
      bank_c = BSW'(addr_w >> RW);
      row_c  = RSW'(addr_w & (ROWS - 1));
    end else begin
      bank_c = BSW'(addr_w & (BANKS - 1));
      row_c  = RSW'(addr_w >> BW);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    rv_d      = 1'b0;
    mem_we_c  = 1'b0;
    wipe_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wipe) begin
          state_d = WIPE;
          cnt_d   = '0;
        end else if (bus.req && bus.rw) begin
          mem_we_c = 1'b1;
        end else if (bus.req) begin
          dout_d = mem_q[bank_c][row_c];
          rv_d   = 1'b1;
        end
      end
      WIPE: begin
        wipe_we_c = 1'b1;
        if (cnt_q == RSW'(ROWS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + RSW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= (WIPE_ON_RESET != 0) ? WIPE : IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rv_q    <= rv_d;
    end
  end

  // Storage is deliberately unreset; a wipe clears one row of every bank per cycle.
  always_ff @(posedge clk) begin
    if (wipe_we_c) begin
      for (int b = 0; b < BANKS; b++) begin
        mem_q[b][cnt_q] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[bank_c][row_c] <= bus.data_in;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.busy     = (state_q == WIPE);
  assign bus.data_out = dout_q;
  assign bus.rd_valid = rv_q;

endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Parametrised single-port RAM of DEPTH words x WIDTH bits, built from BANKS identical sub-banks with a bank-select decode and an output mux.
- Successor to the fixed 4x8 two-bank RAM. Adds parametrised geometry, selectable bank interleaving, a registered read with a valid strobe, and a sequenced bulk-clear ("wipe") engine.
- Serves as the generic storage block for later datapath exercises.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, total words. Power of two, >= BANKS.
- BANKS, 2, number of sub-banks. Power of two, >= 1. ROWS = DEPTH/BANKS.
- INTERLEAVE, 0, bank-select mode:
  - 0: bank = high address bits, row = low bits.
  - 1: bank = low address bits, row = high bits.
- WIPE_ON_RESET, 1, when 1 a wipe sequence starts automatically on reset release.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled at posedge.
- rw  in  1  1 = write, 0 = read. Qualified by req.
- addr  in  clog2(DEPTH)  word address.
- data_in  in  WIDTH  write data.
- wipe  in  1  start bulk clear (single-cycle pulse).
- ready  out  1  block accepts req this cycle.
- busy  out  1  wipe sequence in progress.
- data_out  out  WIDTH  registered read data.
- rd_valid  out  1  data_out updated this cycle.

Behaviour:
- Reset (clr=0, asynchronous):
  - data_out=0, rd_valid=0, row counter=0.
  - state=WIPE if WIPE_ON_RESET=1, else IDLE. busy=WIPE_ON_RESET.
  - Memory arrays are not reset.
- FSM has two states, IDLE and WIPE.
  - ready = (state==IDLE), combinational. busy = (state==WIPE).
- IDLE, at posedge:
  - If wipe=1: go to WIPE with row counter=0. Any req in the same cycle is dropped; wipe has priority.
  - Else if req=1 and rw=1: mem[bank][row] <= data_in. No output change.
  - Else if req=1 and rw=0: data_out <= mem[bank][row]. rd_valid=1 for exactly the next cycle. Read latency is 1 cycle.
- WIPE:
  - Each posedge writes 0 to row=counter in all banks in parallel, then increments the counter.
  - When counter==ROWS-1, that write completes the wipe and state returns to IDLE.
  - busy stays high for exactly ROWS cycles. ready=1 in the cycle after the last wipe write.
- Inputs ignored during WIPE: req (no write, no read, rd_valid stays 0) and wipe (no restart).
- Bank decode, with BW = log2(BANKS):
  - INTERLEAVE=0: bank = addr[AW-1 -: BW], row = addr[AW-BW-1:0].
  - INTERLEAVE=1: bank = addr[BW-1:0], row = addr[AW-1:BW].
  - BANKS=1: no select bits, bank=0.
- Outputs:
  - data_out holds its last read value between reads and during writes and wipes. It never goes Z and is not cleared by a wipe.
  - rd_valid is 0 outside the cycle following an accepted read.
- Hazards:
  - Write at cycle n, then read of the same address at n+1: returns the new data.
  - A read and a write cannot occur in the same cycle (single port).
- Reset asserted mid-wipe: the sequence aborts immediately (async). On release it restarts from row 0 if WIPE_ON_RESET=1, otherwise the block stays IDLE with a partially cleared array.
- All address values are legal, because DEPTH is a power of two.

Test Plan (WIDTH=8, DEPTH=4, BANKS=2 unless stated):
1. clr low 2 cycles then high, WIPE_ON_RESET=1 -> busy=1 and ready=0 for exactly 2 posedges, then ready=1. Reads of addresses 0..3 return 0x00, each with a one-cycle rd_valid pulse.
2. Write 0xA1, 0xB2, 0xC3, 0xD4 to addresses 0..3, then read 3,2,1,0 -> data_out = 0xD4, 0xC3, 0xB2, 0xA1, each one cycle after its request. rd_valid is low during the writes.
3. Write 0xC3 to address 2'b10:
   - INTERLEAVE=0 -> hierarchical peek finds the value in bank1 row0.
   - INTERLEAVE=1 -> bank0 row1.
   - Read-back = 0xC3 in both modes.
4. With memory loaded as in scenario 2, pulse wipe together with req=1, rw=1, addr=1, data_in=0xEE. Then hold req=1 (read addr 0) during busy:
   - The write is dropped; rd_valid stays 0 during busy.
   - Afterwards all addresses read 0x00.
   - data_out keeps 0xA1 until the first post-wipe read.
5. Pulse clr low in the middle of a wipe of a DEPTH=16, BANKS=4 instance (after 2 wipe cycles) -> data_out=0 and rd_valid=0 immediately, without waiting for a clock edge. After release, busy=1 for exactly 4 cycles.
6. Write 0x5A to address 3 at cycle n, read address 3 at n+1 -> data_out=0x5A with rd_valid=1 at n+2. With BANKS=1, DEPTH=8, the same sequence gives the same result.
